// File: rtl/wshb_frame_writer.sv
// Wishbone burst-write master: streams 24-bit RGB pixels from a valid/ready input
// into the framebuffer in raster order (word i at byte address 4*i).
module wshb_frame_writer #(
    parameter int HDISP      = 800,
    parameter int VDISP      = 480,
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic [3:0]  sel,
    output logic        we,
    output logic        stb,
    output logic        cyc,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack,
    output logic        frame_done
);

    localparam int NPIX    = HDISP * VDISP;
    localparam int WCW     = $clog2(NPIX);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int BCW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int NPIX_M1 = NPIX - 1;
    localparam int BL_M1   = BURST_LEN - 1;

    localparam logic [WCW:0]   NPIX_C    = NPIX[WCW:0];
    localparam logic [WCW-1:0] LAST_IDX  = NPIX_M1[WCW-1:0];
    localparam logic [BCW-1:0] LAST_BEAT = BL_M1[BCW-1:0];
    localparam logic [AW:0]    DEPTH_C   = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

    state_t         state;
    logic [BCW-1:0] burst_cnt;
    logic [WCW-1:0] word_cnt;

    logic [24:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count, count_nxt;
    logic           full, empty;
    logic           push, pop, beat;

    logic [24:0]    head;
    logic           head_sof;
    logic [WCW-1:0] wc_base;
    logic [WCW:0]   wc_inc;
    logic           burst_last;

    assign we  = 1'b1;
    assign sel = 4'b1111;
    assign bte = 2'b00;

    assign pix_ready = ~full;
    assign push      = pix_valid & ~full;
    assign pop       = beat;

    assign head     = mem[rd_ptr];
    assign head_sof = head[24];
    assign dat_ms   = {8'h00, head[23:0]};

    // A SOF pixel restarts the raster at word 0 regardless of where we were.
    assign wc_base = head_sof ? '0 : word_cnt;
    assign wc_inc  = {1'b0, wc_base} + 1'b1;
    assign adr     = {{(30-WCW){1'b0}}, wc_base, 2'b00};

    assign burst_last = (burst_cnt == LAST_BEAT);
    assign cti        = burst_last ? 3'b111 : 3'b010;

    // SOF mid-ownership breaks address continuity, so hold it for a fresh cycle.
    assign stb  = (state == BURST) & ~empty & ~(head_sof & (burst_cnt != '0));
    assign beat = stb & ack;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pix_sof, pix_data};
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + 1'b1;
        else if (pop && !push) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= beat && (wc_base == LAST_IDX);
            if (beat) word_cnt <= (wc_inc == NPIX_C) ? '0 : wc_inc[WCW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cyc       <= 1'b0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (!empty) begin
                        state <= BURST;
                        cyc   <= 1'b1;
                    end
                end
                BURST: begin
                    if (beat) burst_cnt <= burst_cnt + 1'b1;
                    // Never park on the bus with stb low; let the display reader in.
                    if ((beat && burst_last) || !stb) begin
                        state <= RELEASE;
                        cyc   <= 1'b0;
                    end
                end
                RELEASE: state <= IDLE;
                default: begin
                    state <= IDLE;
                    cyc   <= 1'b0;
                end
            endcase
        end
    end

endmodule
